// File: rtl/contact_record_writer.sv
// contact_record_writer: front end of the 7-input contact RAM.
// Takes 7-word contact records from the collider stage and turns each
// accepted record into one 7-wide RAM write at word address 7*N. It also
// counts the contacts in each frame, flags full and overflow, and closes
// the frame on a last-record marker.
// Optional feature: define CONTACT_WRITER_DROP_CNT_EN to add the drop_count
// output, a saturating count of records dropped while full.
module contact_record_writer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int RAM_DEPTH   = 84,
  parameter int MAX_RECORDS = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  rec_valid,
  output logic                  rec_ready,
  input  logic                  rec_last,
  input  logic [DATA_WIDTH-1:0] rec_word0,
  input  logic [DATA_WIDTH-1:0] rec_word1,
  input  logic [DATA_WIDTH-1:0] rec_word2,
  input  logic [DATA_WIDTH-1:0] rec_word3,
  input  logic [DATA_WIDTH-1:0] rec_word4,
  input  logic [DATA_WIDTH-1:0] rec_word5,
  input  logic [DATA_WIDTH-1:0] rec_word6,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d0,
  output logic [DATA_WIDTH-1:0] ram_d1,
  output logic [DATA_WIDTH-1:0] ram_d2,
  output logic [DATA_WIDTH-1:0] ram_d3,
  output logic [DATA_WIDTH-1:0] ram_d4,
  output logic [DATA_WIDTH-1:0] ram_d5,
  output logic [DATA_WIDTH-1:0] ram_d6,
  output logic [7:0]            contact_count,
  output logic                  full,
  output logic                  overflow,
  output logic                  done
`ifdef CONTACT_WRITER_DROP_CNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);

  // A record capacity that would not fit in the RAM is clamped to what does fit.
  localparam bit              DEPTH_OK  = (7 * MAX_RECORDS <= RAM_DEPTH);
  localparam int              CAP       = DEPTH_OK ? MAX_RECORDS : (RAM_DEPTH / 7);
  localparam logic [7:0]      MAX_CNT   = 8'(CAP);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(7);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    open_frame;
  logic                    accept;
  logic                    last_slot;
  logic [ADDR_WIDTH-1:0]   addr_q;

  assign rec_ready = (state_q == S_COLLECT);
  assign accept    = rec_valid && rec_ready;
  assign last_slot = (contact_count == MAX_CNT - 8'd1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start only opens a frame from IDLE or DONE.
  always_comb begin
    state_d    = state_q;
    open_frame = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_COLLECT;
          open_frame = 1'b1;
        end
      end
      S_COLLECT: begin
        if (accept && rec_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_d    = S_COLLECT;
          open_frame = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write port and per-frame bookkeeping. The write strobe is a one-cycle
  // pulse following each accept; records accepted while full are dropped.
  // The address register stops advancing at the last slot, so it never
  // exceeds 7*(MAX_RECORDS-1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cs        <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_d0        <= '0;
      ram_d1        <= '0;
      ram_d2        <= '0;
      ram_d3        <= '0;
      ram_d4        <= '0;
      ram_d5        <= '0;
      ram_d6        <= '0;
      addr_q        <= '0;
      contact_count <= '0;
      full          <= 1'b0;
      overflow      <= 1'b0;
      done          <= 1'b0;
    end else begin
      ram_cs <= 1'b0;
      ram_we <= 1'b0;
      if (open_frame) begin
        addr_q        <= '0;
        contact_count <= '0;
        full          <= 1'b0;
        overflow      <= 1'b0;
        done          <= 1'b0;
      end else if (accept) begin
        if (!full) begin
          ram_cs        <= 1'b1;
          ram_we        <= 1'b1;
          ram_addr      <= addr_q;
          ram_d0        <= rec_word0;
          ram_d1        <= rec_word1;
          ram_d2        <= rec_word2;
          ram_d3        <= rec_word3;
          ram_d4        <= rec_word4;
          ram_d5        <= rec_word5;
          ram_d6        <= rec_word6;
          contact_count <= contact_count + 8'd1;
          full          <= last_slot;
          if (!last_slot) addr_q <= addr_q + ADDR_STEP;
        end else begin
          overflow <= 1'b1;
        end
        if (rec_last) done <= 1'b1;
      end
    end
  end

`ifdef CONTACT_WRITER_DROP_CNT_EN
  // Saturating count of records dropped while full in the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      drop_count <= '0;
    else if (open_frame)                             drop_count <= '0;
    else if (accept && full && drop_count != 8'hFF)  drop_count <= drop_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_contact_record_writer.sv
// Bench for contact_record_writer: a table of directed vectors, hand-written
// corner sequences, and randomized traffic checked against a frame-level
// reference model.
module tb_contact_record_writer;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int MAX = 12;

  typedef logic [6:0][DW-1:0] words_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0, rec_valid = 1'b0, rec_last = 1'b0;
  logic          rec_ready;
  logic [DW-1:0] w0 = '0, w1 = '0, w2 = '0, w3 = '0, w4 = '0, w5 = '0, w6 = '0;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] d0, d1, d2, d3, d4, d5, d6;
  logic [7:0]    contact_count;
  logic          full, overflow, done;
`ifdef CONTACT_WRITER_DROP_CNT_EN
  logic [7:0]    drop_count;
`endif

  contact_record_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(84), .MAX_RECORDS(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_last(rec_last),
    .rec_word0(w0), .rec_word1(w1), .rec_word2(w2), .rec_word3(w3),
    .rec_word4(w4), .rec_word5(w5), .rec_word6(w6),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_d0(d0), .ram_d1(d1), .ram_d2(d2), .ram_d3(d3), .ram_d4(d4), .ram_d5(d5), .ram_d6(d6),
    .contact_count(contact_count), .full(full), .overflow(overflow), .done(done)
`ifdef CONTACT_WRITER_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame-level reference model.
  bit     m_open;
  bit     m_done, m_ovf, m_we;
  int     m_n, m_drop, m_addr;
  words_t m_d;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic words_t make_words(input logic [DW-1:0] base);
    words_t w;
    for (int i = 0; i < 7; i++) w[i] = base + DW'(i);
    return w;
  endfunction

  function automatic words_t rand_words();
    words_t w;
    for (int i = 0; i < 7; i++) w[i] = $urandom;
    return w;
  endfunction

  task automatic model_reset();
    m_open = 0; m_done = 0; m_ovf = 0; m_we = 0;
    m_n = 0; m_drop = 0; m_addr = 0; m_d = '0;
  endtask

  task automatic model_step(input bit st, input bit vl, input bit ls, input words_t w);
    m_we = 0;
    if (!m_open) begin
      if (st) begin
        m_open = 1; m_n = 0; m_ovf = 0; m_done = 0; m_drop = 0;
      end
    end else if (vl) begin
      if (m_n < MAX) begin
        m_we = 1; m_addr = 7 * m_n; m_d = w; m_n++;
      end else begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
      if (ls) begin
        m_open = 0; m_done = 1;
      end
    end
  endtask

  task automatic compare_model();
    chk("ram_we", ram_we, m_we);
    chk("ram_cs", ram_cs, m_we);
    if (m_we) begin
      chk("ram_addr", ram_addr, m_addr);
      chk("ram_d", {d6, d5, d4, d3, d2, d1, d0}, m_d);
    end
    chk("contact_count", contact_count, m_n);
    chk("full", full, m_n == MAX);
    chk("overflow", overflow, m_ovf);
    chk("done", done, m_done);
`ifdef CONTACT_WRITER_DROP_CNT_EN
    chk("drop_count", drop_count, m_drop);
`endif
  endtask

  // One clock: drive, check ready, clock, update model, compare.
  task automatic cycle(input bit st, input bit vl, input bit ls, input words_t w);
    start = st; rec_valid = vl; rec_last = ls;
    {w6, w5, w4, w3, w2, w1, w0} = w;
    #1;
    chk("rec_ready", rec_ready, m_open);
    @(posedge clk); #1;
    model_step(st, vl, ls, w);
    compare_model();
    start = 0; rec_valid = 0; rec_last = 0;
  endtask

  // Asynchronous reset pulse between clock edges, with reset-value checks.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_we", ram_we, 1'b0);
    chk("rst_cs", ram_cs, 1'b0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_d", {d6, d5, d4, d3, d2, d1, d0}, 0);
    chk("rst_count", contact_count, 0);
    chk("rst_flags", {full, overflow, done}, 3'b000);
    chk("rst_ready", rec_ready, 1'b0);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    bit st, vl, ls;
    logic [DW-1:0] base;
    bit e_we;
    logic [AW-1:0] e_addr;
    logic [7:0] e_cnt;
    bit e_full, e_ovf, e_done;
  } vec_t;

  vec_t vt[7];

  initial begin
    model_reset();
    #1 do_reset();

    // Directed table: three-record frame, ignored beat in DONE, restart.
    vt[0] = '{1, 0, 0, 32'h000, 0, 0,  0, 0, 0, 0};
    vt[1] = '{0, 1, 0, 32'h000, 1, 0,  1, 0, 0, 0};
    vt[2] = '{0, 1, 0, 32'h100, 1, 7,  2, 0, 0, 0};
    vt[3] = '{0, 1, 1, 32'h200, 1, 14, 3, 0, 0, 1};
    vt[4] = '{0, 1, 0, 32'h300, 0, 0,  3, 0, 0, 1};
    vt[5] = '{1, 0, 0, 32'h000, 0, 0,  0, 0, 0, 0};
    vt[6] = '{0, 1, 1, 32'h400, 1, 0,  1, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      cycle(vt[i].st, vt[i].vl, vt[i].ls, make_words(vt[i].base));
      chk($sformatf("vec%0d_we", i), ram_we, vt[i].e_we);
      if (vt[i].e_we) begin
        chk($sformatf("vec%0d_addr", i), ram_addr, vt[i].e_addr);
        chk($sformatf("vec%0d_d0", i), d0, vt[i].base);
        chk($sformatf("vec%0d_d6", i), d6, vt[i].base + 6);
      end
      chk($sformatf("vec%0d_cnt", i), contact_count, vt[i].e_cnt);
      chk($sformatf("vec%0d_flags", i), {full, overflow, done},
          {vt[i].e_full, vt[i].e_ovf, vt[i].e_done});
    end

    // Fill to capacity, then three drops, the last one closing the frame.
    cycle(1, 0, 0, '0);
    for (int r = 0; r < MAX; r++) begin
      cycle(0, 1, 0, make_words(32'h100 * r));
      if (r == MAX - 1) begin
        chk("twelfth_addr", ram_addr, 77);
        chk("full_on_12th", full, 1'b1);
      end else begin
        chk("not_full_yet", full, 1'b0);
      end
    end
    cycle(0, 1, 0, make_words(32'hA00));
    chk("drop_no_we", ram_we, 1'b0);
    cycle(0, 1, 0, make_words(32'hB00));
    cycle(0, 1, 1, make_words(32'hC00));
    chk("last_full_no_we", ram_we, 1'b0);
    chk("last_full_state", {contact_count, overflow, done}, {8'd12, 1'b1, 1'b1});
`ifdef CONTACT_WRITER_DROP_CNT_EN
    chk("drop_count3", drop_count, 8'd3);
`endif

    // Restart from DONE, valid every other cycle, start ignored mid-frame.
    cycle(1, 0, 0, '0);
    for (int r = 0; r < 4; r++) begin
      cycle(r == 2, 1, 0, make_words(32'h5000 + 32'h10 * r));
      chk("gap_write_addr", ram_addr, 7 * r);
      cycle(0, 0, 0, '0);
      chk("gap_no_we", ram_we, 1'b0);
    end
    chk("gap_count", contact_count, 8'd4);

    // Reset in the cycle right after an accept kills the pending pulse.
    cycle(0, 1, 0, make_words(32'h6000));
    chk("pre_reset_we", ram_we, 1'b1);
    do_reset();
    cycle(0, 1, 1, make_words(32'h7000));
    chk("idle_ignores", ram_we, 1'b0);

    // Randomized traffic, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 29) == 0, rand_words());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
